// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and default constants for the multdiv issue controller.
package multdiv_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam int unsigned DEF_TIMEOUT      = 64;
  localparam int unsigned DEF_RSTATUS_REG  = 30;
  localparam int unsigned DEF_MUL_EXC_CODE = 4;
  localparam int unsigned DEF_DIV_EXC_CODE = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Operation captured on acceptance and held until the next acceptance.
  typedef struct packed {
    logic             is_div;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } op_t;

endpackage

// File: rtl/multdiv_issue_ctrl_timeout_counter.sv
// Cycle counter for the response timeout.
// Ports: clk, rst_n, clear_i (synchronous clear, wins over enable),
//        en_i (count up), tc_c_o (count has reached TIMEOUT-1).
module multdiv_issue_ctrl_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear beats enable.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Pipeline-side initiator for the multdiv unit: captures a MUL/DIV, pulses the
// start strobe, stalls until the result returns (or times out), then issues a
// one-cycle writeback of the result or an rstatus exception code. A flushed op
// is drained so that its late completion can never retire a younger op.
// Ports: clock/reset_n; op_* request from execute; flush; ctrl_MULT/ctrl_DIV
//        start pulses and data_operandA/B to multdiv; data_result/
//        data_exception/data_resultRDY from multdiv; stall; wb_* writeback;
//        busy.
module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned RSTATUS_REG  = DEF_RSTATUS_REG,
  parameter int unsigned MUL_EXC_CODE = DEF_MUL_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE = DEF_DIV_EXC_CODE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic             op_is_div,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [REG_W-1:0] op_rd,
  input  logic             flush,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [XLEN-1:0]  data_operandA,
  output logic [XLEN-1:0]  data_operandB,
  input  logic [XLEN-1:0]  data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             busy
);

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic             ctrl_mult_q, ctrl_mult_d;
  logic             ctrl_div_q, ctrl_div_d;
  logic             wb_valid_q, wb_valid_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             busy_q;
  logic             cnt_clear, cnt_en, cnt_tc;
  logic [XLEN-1:0]  exc_code;

  multdiv_issue_ctrl_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clock),
    .rst_n   (reset_n),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .tc_c_o  (cnt_tc)
  );

  assign exc_code = op_q.is_div ? XLEN'(DIV_EXC_CODE) : XLEN'(MUL_EXC_CODE);

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          op_d        = '{is_div: op_is_div, rd: op_rd, a: op_a, b: op_b};
          ctrl_mult_d = !op_is_div;
          ctrl_div_d  = op_is_div;
          state_d     = START;
        end
      end
      START: begin
        cnt_clear = 1'b1;
        state_d   = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flush) begin
          // A response or expiry this cycle already retires the squashed op.
          cnt_en  = 1'b1;
          state_d = (data_resultRDY || cnt_tc) ? IDLE : DRAIN;
        end else if (data_resultRDY) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = data_exception ? REG_W'(RSTATUS_REG) : op_q.rd;
          wb_data_d  = data_exception ? exc_code : data_result;
          state_d    = DONE;
        end else if (cnt_tc) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = REG_W'(RSTATUS_REG);
          wb_data_d  = exc_code;
          state_d    = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (data_resultRDY || cnt_tc) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // Stall must react to op_valid in the same cycle, so it is decoded combinationally.
  assign stall = reset_n & (((state_q == IDLE) & op_valid & ~flush) |
                            (state_q == START) |
                            (state_q == WAIT) |
                            ((state_q == DRAIN) & op_valid));

  assign ctrl_MULT     = ctrl_mult_q;
  assign ctrl_DIV      = ctrl_div_q;
  assign data_operandA = op_q.a;
  assign data_operandB = op_q.b;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with hand-computed expectations.
module tb_multdiv_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic        op_valid;
  logic        op_is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic        flush;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_mult   = 0;
  int n_div    = 0;
  int n_wb     = 0;

  multdiv_issue_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .op_valid       (op_valid),
    .op_is_div      (op_is_div),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_rd          (op_rd),
    .flush          (flush),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count start pulses and writebacks, sampled mid-cycle.
  always @(negedge clock) begin
    if (ctrl_MULT) n_mult++;
    if (ctrl_DIV)  n_div++;
    if (wb_valid)  n_wb++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic present(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    op_valid  = 1'b1;
    op_is_div = div;
    op_a      = a;
    op_b      = b;
    op_rd     = rd;
  endtask

  initial begin
    int m0, d0, w0, cnt;

    reset_n = 1'b0; op_valid = 1'b1; op_is_div = 1'b0; op_a = '0; op_b = '0;
    op_rd = '0; flush = 1'b0; data_result = '0; data_exception = 1'b0;
    data_resultRDY = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_opA", data_operandA, 32'd0);
    op_valid = 1'b0;
    reset_n  = 1'b1;
    tick();

    // MUL 7x6 -> r5, RDY two cycles after the start pulse.
    m0 = n_mult; w0 = n_wb;
    present(1'b0, 32'd7, 32'd6, 5'd5);
    #1 check("s1_stall_t0", 32'(stall), 32'd1);
    tick();
    op_valid = 1'b0;
    check("s1_ctrl_mult", 32'(ctrl_MULT), 32'd1);
    check("s1_ctrl_div", 32'(ctrl_DIV), 32'd0);
    check("s1_opA", data_operandA, 32'd7);
    check("s1_opB", data_operandB, 32'd6);
    check("s1_stall_t1", 32'(stall), 32'd1);
    tick();
    check("s1_ctrl_mult_t2", 32'(ctrl_MULT), 32'd0);
    check("s1_stall_t2", 32'(stall), 32'd1);
    tick();
    data_resultRDY = 1'b1; data_result = 32'd42;
    #1 check("s1_stall_t3", 32'(stall), 32'd1);
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s1_wb_valid", 32'(wb_valid), 32'd1);
    check("s1_wb_rd", 32'(wb_rd), 32'd5);
    check("s1_wb_data", wb_data, 32'd42);
    check("s1_stall_done", 32'(stall), 32'd0);
    tick();
    check("s1_wb_valid_off", 32'(wb_valid), 32'd0);
    check("s1_busy_off", 32'(busy), 32'd0);
    check("s1_mult_pulses", 32'(n_mult - m0), 32'd1);
    check("s1_wb_count", 32'(n_wb - w0), 32'd1);

    // DIV 100/0 -> exception after 33 cycles.
    d0 = n_div; w0 = n_wb;
    present(1'b1, 32'd100, 32'd0, 5'd7);
    tick();
    op_valid = 1'b0;
    check("s2_ctrl_div", 32'(ctrl_DIV), 32'd1);
    cnt = 0;
    for (int i = 0; i < 33; i++) begin
      tick();
      if (!stall) cnt++;
    end
    data_resultRDY = 1'b1; data_exception = 1'b1; data_result = 32'hFFFF_FFFF;
    tick();
    data_resultRDY = 1'b0; data_exception = 1'b0; data_result = '0;
    check("s2_wb_valid", 32'(wb_valid), 32'd1);
    check("s2_wb_rd", 32'(wb_rd), 32'd30);
    check("s2_wb_data", wb_data, 32'd5);
    tick();
    check("s2_stall_drops", 32'(cnt), 32'd0);
    check("s2_div_pulses", 32'(n_div - d0), 32'd1);
    check("s2_wb_count", 32'(n_wb - w0), 32'd1);

    // MUL with no response: timeout after 64 WAIT cycles.
    present(1'b0, 32'd5, 32'd5, 5'd9);
    tick();
    op_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (wb_valid) cnt++;
    end
    check("s3_early_wb", 32'(cnt), 32'd0);
    check("s3_stall_last_wait", 32'(stall), 32'd1);
    tick();
    check("s3_wb_valid", 32'(wb_valid), 32'd1);
    check("s3_wb_rd", 32'(wb_rd), 32'd30);
    check("s3_wb_data", wb_data, 32'd4);
    tick();

    // Flush in WAIT, younger MUL 3x3 waits for the stale response.
    m0 = n_mult; w0 = n_wb;
    present(1'b0, 32'd1, 32'd1, 5'd3);
    tick();
    op_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    present(1'b0, 32'd3, 32'd3, 5'd8);
    #1 check("s4_drain_stall", 32'(stall), 32'd1);
    check("s4_drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("s4_no_early_issue", 32'(n_mult - m0), 32'd1);
    data_resultRDY = 1'b1; data_result = 32'd1;
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s4_idle_no_pulse", 32'(ctrl_MULT), 32'd0);
    check("s4_idle_opA_held", data_operandA, 32'd1);
    check("s4_no_wb_flushed", 32'(n_wb - w0), 32'd0);
    tick();
    op_valid = 1'b0;
    check("s4_ctrl_mult", 32'(ctrl_MULT), 32'd1);
    check("s4_opA", data_operandA, 32'd3);
    tick();
    data_resultRDY = 1'b1; data_result = 32'd9;
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s4_wb_valid", 32'(wb_valid), 32'd1);
    check("s4_wb_rd", 32'(wb_rd), 32'd8);
    check("s4_wb_data", wb_data, 32'd9);
    tick();
    check("s4_wb_count", 32'(n_wb - w0), 32'd1);

    // Flush and RDY together in WAIT: op discarded, straight to IDLE.
    w0 = n_wb;
    present(1'b0, 32'd4, 32'd4, 5'd11);
    tick();
    op_valid = 1'b0;
    tick();
    flush = 1'b1; data_resultRDY = 1'b1; data_result = 32'd77;
    tick();
    flush = 1'b0; data_resultRDY = 1'b0; data_result = '0;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("s5_wb_count", 32'(n_wb - w0), 32'd0);

    // op_valid together with flush in IDLE is not accepted.
    present(1'b0, 32'd2, 32'd2, 5'd2);
    flush = 1'b1;
    #1 check("s5_idle_flush_stall", 32'(stall), 32'd0);
    tick();
    op_valid = 1'b0; flush = 1'b0;
    check("s5_idle_flush_busy", 32'(busy), 32'd0);
    check("s5_idle_flush_ctrl", 32'(ctrl_MULT), 32'd0);

    // Back-to-back DIV 20/4 -> r1, then MUL 2x8 -> r0.
    m0 = n_mult; d0 = n_div; w0 = n_wb;
    present(1'b1, 32'd20, 32'd4, 5'd1);
    tick();
    op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D;
    check("s6_ctrl_div", 32'(ctrl_DIV), 32'd1);
    tick();
    check("s6_div_opA", data_operandA, 32'd20);
    check("s6_div_opB", data_operandB, 32'd4);
    data_resultRDY = 1'b1; data_result = 32'd5;
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s6_div_wb_rd", 32'(wb_rd), 32'd1);
    check("s6_div_wb_data", wb_data, 32'd5);
    tick();
    present(1'b0, 32'd2, 32'd8, 5'd0);
    tick();
    op_valid = 1'b0; op_a = 32'h1234_5678; op_b = 32'h8765_4321;
    check("s6_ctrl_mult", 32'(ctrl_MULT), 32'd1);
    check("s6_ctrl_div_off", 32'(ctrl_DIV), 32'd0);
    tick();
    check("s6_mul_opA", data_operandA, 32'd2);
    check("s6_mul_opB", data_operandB, 32'd8);
    tick();
    data_resultRDY = 1'b1; data_result = 32'd16;
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s6_mul_wb_valid", 32'(wb_valid), 32'd1);
    check("s6_mul_wb_rd", 32'(wb_rd), 32'd0);
    check("s6_mul_wb_data", wb_data, 32'd16);
    tick();
    check("s6_mult_pulses", 32'(n_mult - m0), 32'd1);
    check("s6_div_pulses", 32'(n_div - d0), 32'd1);
    check("s6_wb_count", 32'(n_wb - w0), 32'd2);

    // Reset asserted mid-WAIT, then a late RDY.
    present(1'b0, 32'd9, 32'd9, 5'd4);
    tick();
    op_valid = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1;
    check("s7_stall", 32'(stall), 32'd0);
    check("s7_busy", 32'(busy), 32'd0);
    check("s7_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check("s7_opA", data_operandA, 32'd0);
    check("s7_opB", data_operandB, 32'd0);
    tick();
    reset_n = 1'b1;
    w0 = n_wb;
    data_resultRDY = 1'b1; data_result = 32'd81;
    tick();
    data_resultRDY = 1'b0; data_result = '0;
    check("s7_wb_valid", 32'(wb_valid), 32'd0);
    check("s7_busy_after", 32'(busy), 32'd0);
    tick();
    check("s7_wb_count", 32'(n_wb - w0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
